instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer_if.sv | 14 +
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: ROM read port and core run/done handshake bundle
//   master (sequencer): drives rom_en, rom_addr, cpu_din, cpu_run; receives rom_rdata, cpu_done
//   slave  (ROM/core) : the mirror image
//   rom_rdata is valid the cycle after rom_en; cpu_done is sampled only while a word executes
interface instr_sequencer_if #(parameter int ADDR_W = 8);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_rdata;
    logic [15:0]       cpu_din;
    logic              cpu_run;
    logic              cpu_done;
    modport master (output rom_en, rom_addr, cpu_din, cpu_run, input rom_rdata, cpu_done);
    modport slave  (input rom_en, rom_addr, cpu_din, cpu_run, output rom_rdata, cpu_done);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches ROM words and feeds them one instruction at a time to the 16-bit core
//   clk, resetn (sync, active-low), start (pulse, restarts at address 0 from IDLE/HALT)
//   bus         : instr_sequencer_if.master (ROM port + core din/run/done)
//   busy        : high outside IDLE and HALT;  halted : high in HALT
//   err         : sticky, truncated mvi (or watchdog expiry)
//   pc          : next word address;  instr_count : completed instructions, saturating
//   Optional INSTR_SEQ_WATCHDOG_EN: abort to HALT with err after TIMEOUT_CYC EXEC cycles without done.
module instr_sequencer #(
    parameter int         ADDR_W      = 8,
    parameter int         PROG_LEN    = 256,
    parameter logic [2:0] HALT_OPCODE = 3'b111,
    parameter int         TIMEOUT_CYC = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    instr_sequencer_if.master  bus,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [ADDR_W-1:0]  pc,
    output logic [15:0]        instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, FETCH_IMM, LATCH_IMM, ISSUE, EXEC, HALT} state_t;
    localparam logic [2:0] OP_MVI = 3'b001;
    // One extra bit so a full-size program (PROG_LEN == 2**ADDR_W) can still reach its end address.
    localparam logic [ADDR_W:0] END_PC = (ADDR_W + 1)'(PROG_LEN);

    if (PROG_LEN < 1 || PROG_LEN > 2 ** ADDR_W) $error("PROG_LEN out of range");
    if (TIMEOUT_CYC < 1) $error("TIMEOUT_CYC must be at least 1");

    state_t          state;
    logic [ADDR_W:0] pc_r;
    logic [15:0]     instr_reg, imm_reg, din_r;
    logic            rom_en_r, run_r;
`ifdef INSTR_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
`endif

    assign bus.rom_en   = rom_en_r;
    assign bus.rom_addr = pc_r[ADDR_W-1:0];
    assign bus.cpu_din  = din_r;
    assign bus.cpu_run  = run_r;
    assign pc           = pc_r[ADDR_W-1:0];

    // Strobes are registered: each transition loads the value the next state must present,
    // so rom_en in FETCH/FETCH_IMM already reflects whether the program end was reached.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            pc_r        <= '0;
            instr_count <= '0;
            err         <= 1'b0;
            instr_reg   <= '0;
            imm_reg     <= '0;
            din_r       <= '0;
            rom_en_r    <= 1'b0;
            run_r       <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
`ifdef INSTR_SEQ_WATCHDOG_EN
            wd          <= '0;
`endif
        end else begin
            case (state)
                IDLE, HALT: if (start) begin
                    state       <= FETCH;
                    pc_r        <= '0;
                    instr_count <= '0;
                    err         <= 1'b0;
                    rom_en_r    <= END_PC != '0;
                    busy        <= 1'b1;
                    halted      <= 1'b0;
                end
                FETCH: begin
                    rom_en_r <= 1'b0;
                    if (pc_r == END_PC) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else state <= LATCH;
                end
                LATCH: begin
                    instr_reg <= bus.rom_rdata;
                    pc_r      <= pc_r + 1'b1;
                    if (bus.rom_rdata[8:6] == HALT_OPCODE) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (bus.rom_rdata[8:6] == OP_MVI) begin
                        state    <= FETCH_IMM;
                        rom_en_r <= (pc_r + 1'b1) != END_PC;
                    end else begin
                        state <= ISSUE;
                        run_r <= 1'b1;
                        din_r <= bus.rom_rdata;
                    end
                end
                FETCH_IMM: begin
                    rom_en_r <= 1'b0;
                    if (pc_r == END_PC) begin
                        state  <= HALT;
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else state <= LATCH_IMM;
                end
                LATCH_IMM: begin
                    imm_reg <= bus.rom_rdata;
                    pc_r    <= pc_r + 1'b1;
                    state   <= ISSUE;
                    run_r   <= 1'b1;
                    din_r   <= instr_reg;
                end
                ISSUE: begin
                    state <= EXEC;
                    din_r <= instr_reg[8:6] == OP_MVI ? imm_reg : instr_reg;
`ifdef INSTR_SEQ_WATCHDOG_EN
                    wd    <= '0;
`endif
                end
                EXEC: if (bus.cpu_done) begin
                    instr_count <= instr_count + {15'd0, ~&instr_count};
                    state       <= FETCH;
                    run_r       <= 1'b0;
                    rom_en_r    <= pc_r != END_PC;
                end
`ifdef INSTR_SEQ_WATCHDOG_EN
                else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                    err    <= 1'b1;
                    run_r  <= 1'b0;
                    state  <= HALT;
                    busy   <= 1'b0;
                    halted <= 1'b1;
                end else wd <= wd + 1'b1;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench with a ROM, a small core model and a program-level reference
module tb_instr_sequencer;
    localparam int PL = 16;
    typedef struct {logic [15:0] word; logic [15:0] xdin; int len;} iss_t;
    typedef struct {int pc; int cnt; logic err;} fin_t;

    logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic        busy, halted, err;
    logic [7:0]  pc;
    logic [15:0] instr_count;
    int          vec = 0, miss = 0;
    logic [15:0] rom [256];
    logic [15:0] mr [8];
    logic [15:0] r [8];
    logic [15:0] ir = '0;
    int          step = 0;
    logic        mon_off = 1'b0, hold_done = 1'b0, noise = 1'b0, core_clr = 1'b0;
    iss_t        exp_q [$];
    fin_t        fin_q [$];

    instr_sequencer_if #(.ADDR_W(8)) bus ();

    instr_sequencer #(.ADDR_W(8), .PROG_LEN(PL), .HALT_OPCODE(3'b111), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .bus(bus), .busy(busy), .halted(halted),
        .err(err), .pc(pc), .instr_count(instr_count));

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.rom_en) bus.rom_rdata <= rom[bus.rom_addr];

    // Core: latches IR in step 0, mv/mvi finish in step 1, add/sub in step 3.
    always @(posedge clk) begin
        if (core_clr) for (int i = 0; i < 8; i++) r[i] <= '0;
        if (!bus.cpu_run) step <= 0;
        else begin
            step <= step + 1;
            if (step == 0) ir <= bus.cpu_din;
            else if (step == 1 && ir[8:6] == 3'd0) r[ir[5:3]] <= r[ir[2:0]];
            else if (step == 1 && ir[8:6] == 3'd1) r[ir[5:3]] <= bus.cpu_din;
            else if (step == 3 && ir[8:6] == 3'd2) r[ir[5:3]] <= r[ir[5:3]] + r[ir[2:0]];
            else if (step == 3 && ir[8:6] == 3'd3) r[ir[5:3]] <= r[ir[5:3]] - r[ir[2:0]];
        end
    end
    assign bus.cpu_done = bus.cpu_run ?
        (!hold_done && step == ((ir[8:6] == 3'd2 || ir[8:6] == 3'd3) ? 3 : 1)) : noise;

    always @(negedge clk) noise = 1'($urandom_range(0, 1));

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        vec++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Monitor: pops one expectation per issued instruction and one per halt.
    bit   act = 0, have = 0, prev_h = 0;
    int   len = 0;
    iss_t cur;
    fin_t fin;
    always @(negedge clk) begin
        if (!resetn || mon_off) act = 0;
        else if (bus.cpu_run) begin
            if (!act) begin
                act = 1;
                len = 1;
                have = exp_q.size() > 0;
                if (!have) begin
                    vec++;
                    miss++;
                    $display("FAIL issue_unexpected: got din %h, want no issue", bus.cpu_din);
                end else begin
                    cur = exp_q.pop_front();
                    chk("issue_din", bus.cpu_din, cur.word);
                end
            end else begin
                len++;
                if (have) chk("exec_din", bus.cpu_din, cur.xdin);
            end
        end else if (act) begin
            act = 0;
            if (have) chk("run_len", len, cur.len);
        end
        if (resetn && !mon_off && halted && !prev_h) begin
            if (fin_q.size() == 0) begin
                vec++;
                miss++;
                $display("FAIL halt_unexpected: got halt at pc %0d, want none", pc);
            end else begin
                fin = fin_q.pop_front();
                chk("halt_pc", pc, fin.pc);
                chk("halt_count", instr_count, fin.cnt);
                chk("halt_err", err, fin.err);
                chk("pending_issues", exp_q.size(), 0);
            end
        end
        prev_h = halted;
    end

    // Reference: walk the program as a list of instructions.
    task automatic model();
        int p = 0, cnt = 0;
        logic e = 1'b0;
        logic [15:0] w, imm;
        logic [2:0] op, x, y;
        for (int i = 0; i < 8; i++) mr[i] = '0;
        while (p < PL) begin
            w = rom[p];
            p++;
            op = w[8:6];
            x = w[5:3];
            y = w[2:0];
            if (op == 3'd7) break;
            if (op == 3'd1) begin
                if (p == PL) begin
                    e = 1'b1;
                    break;
                end
                imm = rom[p];
                p++;
                exp_q.push_back('{w, imm, 2});
                mr[x] = imm;
            end else begin
                exp_q.push_back('{w, w, (op == 3'd2 || op == 3'd3) ? 4 : 2});
                if (op == 3'd0) mr[x] = mr[y];
                else if (op == 3'd2) mr[x] = mr[x] + mr[y];
                else if (op == 3'd3) mr[x] = mr[x] - mr[y];
            end
            cnt++;
        end
        fin_q.push_back('{p, cnt, e});
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h01C0;
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        int o;
        w = 16'($urandom);
        o = $urandom_range(0, 15);
        w[8:6] = 3'(o < 8 ? o : $urandom_range(0, 6));
        return w;
    endfunction

    task automatic run_prog(bit poke);
        model();
        @(posedge clk);
        #1 core_clr = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 core_clr = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_err", err, 0);
        if (poke) begin
            repeat (2) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int t = 0; t < 400 && !halted; t++) @(negedge clk);
        chk("halt_reached", halted, 1);
        if (!halted) begin
            exp_q.delete();
            fin_q.delete();
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk("core_reg", r[i], mr[i]);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        int n;
        clear_rom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_pc", pc, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_run", bus.cpu_run, 0);
        chk("rst_rom_en", bus.rom_en, 0);
        chk("rst_din", bus.cpu_din, 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        rom[0] = 16'h0008;
        run_prog(0);
        chk("mv_pc", pc, 2);
        chk("mv_count", instr_count, 1);

        clear_rom();
        rom[0] = 16'h0050;
        rom[1] = 16'h1234;
        run_prog(0);
        chk("mvi_pc", pc, 3);
        chk("mvi_r2", r[2], 16'h1234);

        clear_rom();
        rom[0] = 16'h0040;
        rom[1] = 16'h0005;
        rom[2] = 16'h0048;
        rom[3] = 16'h0007;
        rom[4] = 16'h0081;
        run_prog(1);
        chk("add_r0", r[0], 16'h000C);
        chk("add_count", instr_count, 3);

        for (int i = 0; i < 14; i++) rom[i] = {7'($urandom), 3'b000, 6'($urandom)};
        rom[14] = 16'h0000;
        rom[15] = 16'h0040;
        run_prog(1);
        chk("trunc_err", err, 1);
        chk("trunc_pc", pc, 16);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < PL; i++) rom[i] = rnd_word();
            run_prog(k[0]);
        end

        mon_off = 1'b1;
        hold_done = 1'b1;
        clear_rom();
        rom[0] = 16'h0008;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20 && !bus.cpu_run; t++) @(negedge clk);
        n = 0;
        while (bus.cpu_run && n < 40) begin
            n++;
            @(negedge clk);
        end
`ifdef INSTR_SEQ_WATCHDOG_EN
        chk("wd_run_len", n, 9);
        chk("wd_halted", halted, 1);
        chk("wd_err", err, 1);
        chk("wd_count", instr_count, 0);
`else
        chk("hang_run_len", n, 40);
        chk("hang_busy", busy, 1);
        chk("hang_halted", halted, 0);
`endif
        hold_done = 1'b0;
        pulse_reset();

        clear_rom();
        rom[0] = 16'h0081;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20 && !bus.cpu_run; t++) @(negedge clk);
        @(negedge clk);
        chk("mid_in_exec", bus.cpu_run, 1);
        pulse_reset();
        @(negedge clk);
        chk("mid_run", bus.cpu_run, 0);
        chk("mid_busy", busy, 0);
        chk("mid_pc", pc, 0);
        chk("mid_count", instr_count, 0);
        repeat (3) @(negedge clk);
        chk("mid_idle", busy, 0);
        mon_off = 1'b0;

        for (int i = 0; i < PL; i++) rom[i] = rnd_word();
        run_prog(1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
